// File: rtl/mouse_tracker.sv
// Cursor engine: accumulates PS/2 deltas into a clamped screen position, maps it
// onto a block grid with an iterative divider, and derives click / cheat pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | block outputs stable, waiting for a position update
// LOAD    | capture grid-relative offsets and out-of-range flag
// DIV     | repeated subtraction, one block per axis per cycle
// DONE    | publish block indices and mouse_valid
module mouse_tracker #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int GRID_X0      = 32,
    parameter int GRID_Y0      = 80,
    parameter int BLOCK_W      = 32,
    parameter int BLOCK_H      = 48,
    parameter int GRID_COLS    = 18,
    parameter int GRID_ROWS    = 8,
    parameter int SENS_SHIFT   = 0,
    parameter int CHEAT_CLICKS = 5,
    parameter int CHEAT_GAP    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       pkt_valid,
    input  logic [8:0] pkt_dx,
    input  logic [8:0] pkt_dy,
    input  logic       pkt_x_ovf,
    input  logic       pkt_y_ovf,
    input  logic [2:0] pkt_btn,
    output logic [9:0] mouse_x,
    output logic [8:0] mouse_y,
    output logic       mouse_valid,
    output logic [4:0] mouse_block_x,
    output logic [2:0] mouse_block_y,
    output logic       map_busy,
    output logic       l_click,
    output logic       r_click,
    output logic       l_held,
    output logic       cheat_activate
);

    localparam logic signed [11:0] X_MAX   = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] Y_MAX   = 12'(SCREEN_H - 1);
    localparam logic [9:0]         X_MAX10 = 10'(SCREEN_W - 1);
    localparam logic [8:0]         Y_MAX9  = 9'(SCREEN_H - 1);
    localparam logic [9:0]         X_RST   = 10'(SCREEN_W / 2);
    localparam logic [8:0]         Y_RST   = 9'(SCREEN_H / 2);
    localparam logic [11:0]        X_LO    = 12'(GRID_X0);
    localparam logic [11:0]        X_HI    = 12'(GRID_X0 + GRID_COLS * BLOCK_W);
    localparam logic [11:0]        Y_LO    = 12'(GRID_Y0);
    localparam logic [11:0]        Y_HI    = 12'(GRID_Y0 + GRID_ROWS * BLOCK_H);
    localparam logic [11:0]        BW      = 12'(BLOCK_W);
    localparam logic [11:0]        BH      = 12'(BLOCK_H);
    localparam int                 GAP_W   = $clog2(CHEAT_GAP + 1);
    localparam int                 CNT_W   = $clog2(CHEAT_CLICKS + 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(CHEAT_GAP);
    localparam logic [CNT_W-1:0]   CNT_FIRE = CNT_W'(CHEAT_CLICKS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_DONE
    } map_state_t;

    logic [9:0]        r_x;
    logic [8:0]        r_y;
    logic signed [11:0] w_dx_ext, w_dy_ext, w_sx, w_sy, w_sum_x, w_sum_y;
    logic [9:0]        w_x_new;
    logic [8:0]        w_y_new;

    logic              r_left, r_right, r_l_click, r_r_click, r_cheat;
    logic [CNT_W-1:0]  r_cnt;
    logic [GAP_W-1:0]  r_gap;
    logic              w_l_rise, w_r_rise, w_timeout, w_cheat_hit;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_unused_mid;

    map_state_t        r_state, w_next_state;
    logic              r_upd, w_busy;
    logic [11:0]       r_rx, r_ry, w_rx, w_ry;
    logic [4:0]        r_col, r_bx;
    logic [2:0]        r_row, r_by;
    logic              r_oor, r_valid;
    logic              w_pos_oor, w_x_more, w_y_more, w_publish;

    // Position datapath: 12-bit signed sums cannot wrap for any 9-bit delta.
    assign w_dx_ext = {{3{pkt_dx[8]}}, pkt_dx};
    assign w_dy_ext = {{3{pkt_dy[8]}}, pkt_dy};
    assign w_sx     = w_dx_ext >>> SENS_SHIFT;
    assign w_sy     = w_dy_ext >>> SENS_SHIFT;
    assign w_sum_x  = $signed({2'b00, r_x}) + w_sx;
    assign w_sum_y  = $signed({3'b000, r_y}) - w_sy;

    always_comb begin
        w_x_new = w_sum_x[9:0];
        w_y_new = w_sum_y[8:0];
        if (w_sum_x < 12'sd0) begin
            w_x_new = '0;
        end else if (w_sum_x > X_MAX) begin
            w_x_new = X_MAX10;
        end
        if (w_sum_y < 12'sd0) begin
            w_y_new = '0;
        end else if (w_sum_y > Y_MAX) begin
            w_y_new = Y_MAX9;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= X_RST;
            r_y <= Y_RST;
        end else if (interboard_rst) begin
            r_x <= X_RST;
            r_y <= Y_RST;
        end else if (pkt_valid) begin
            if (!pkt_x_ovf) r_x <= w_x_new;
            if (!pkt_y_ovf) r_y <= w_y_new;
        end
    end

    // Cheat counter runs on the raw rise so cheat_activate lines up with r_click.
    assign w_unused_mid = pkt_btn[2];
    assign w_l_rise     = pkt_valid & pkt_btn[0] & ~r_left;
    assign w_r_rise     = pkt_valid & pkt_btn[1] & ~r_right;
    assign w_timeout    = (r_gap == GAP_W'(1));
    assign w_cnt_next   = w_timeout ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_cheat_hit  = w_r_rise & ~w_l_rise & (w_cnt_next == CNT_FIRE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_left    <= 1'b0;
            r_right   <= 1'b0;
            r_l_click <= 1'b0;
            r_r_click <= 1'b0;
            r_cheat   <= 1'b0;
            r_cnt     <= '0;
            r_gap     <= '0;
        end else if (interboard_rst) begin
            r_left    <= 1'b0;
            r_right   <= 1'b0;
            r_l_click <= 1'b0;
            r_r_click <= 1'b0;
            r_cheat   <= 1'b0;
            r_cnt     <= '0;
            r_gap     <= '0;
        end else begin
            r_l_click <= w_l_rise;
            r_r_click <= w_r_rise;
            r_cheat   <= w_cheat_hit;
            if (pkt_valid) begin
                r_left  <= pkt_btn[0];
                r_right <= pkt_btn[1];
            end
            if (w_l_rise) begin
                r_cnt <= '0;
                if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
            end else if (w_r_rise) begin
                r_gap <= GAP_LOAD;
                r_cnt <= w_cheat_hit ? '0 : w_cnt_next;
            end else if (w_timeout) begin
                r_gap <= '0;
                r_cnt <= '0;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    // Mapping FSM
    assign w_pos_oor = ({2'b00, r_x} < X_LO) | ({2'b00, r_x} >= X_HI) |
                       ({3'b000, r_y} < Y_LO) | ({3'b000, r_y} >= Y_HI);
    assign w_rx      = {2'b00, r_x} - X_LO;
    assign w_ry      = {3'b000, r_y} - Y_LO;
    assign w_x_more  = (r_rx >= BW);
    assign w_y_more  = (r_ry >= BH);
    // A result is dropped if the position moved after it was captured.
    assign w_publish = (r_state == ST_DONE) & ~r_upd & ~pkt_valid;

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_IDLE;
            end
            ST_LOAD: begin
                w_busy       = 1'b1;
                w_next_state = w_pos_oor ? ST_DONE : ST_DIV;
            end
            ST_DIV: begin
                w_busy = 1'b1;
                if (!w_x_more && !w_y_more) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (r_upd) w_next_state = ST_LOAD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_upd   <= 1'b1;
        end else if (interboard_rst) begin
            r_state <= ST_IDLE;
            r_upd   <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_upd   <= pkt_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx    <= '0;
            r_ry    <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_oor   <= 1'b0;
            r_valid <= 1'b0;
            r_bx    <= '0;
            r_by    <= '0;
        end else if (interboard_rst) begin
            r_rx    <= '0;
            r_ry    <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_oor   <= 1'b0;
            r_valid <= 1'b0;
            r_bx    <= '0;
            r_by    <= '0;
        end else begin
            if (r_state == ST_LOAD) begin
                r_rx  <= w_rx;
                r_ry  <= w_ry;
                r_col <= '0;
                r_row <= '0;
                r_oor <= w_pos_oor;
            end else if (r_state == ST_DIV) begin
                if (w_x_more) begin
                    r_rx  <= r_rx - BW;
                    r_col <= r_col + 5'd1;
                end
                if (w_y_more) begin
                    r_ry  <= r_ry - BH;
                    r_row <= r_row + 3'd1;
                end
            end
            if (pkt_valid) begin
                r_valid <= 1'b0;
            end else if (w_publish) begin
                r_valid <= ~r_oor;
                if (!r_oor) begin
                    r_bx <= r_col;
                    r_by <= r_row;
                end
            end
        end
    end

    assign mouse_x        = r_x;
    assign mouse_y        = r_y;
    assign mouse_valid    = r_valid;
    assign mouse_block_x  = r_bx;
    assign mouse_block_y  = r_by;
    assign map_busy       = w_busy;
    assign l_click        = r_l_click;
    assign r_click        = r_r_click;
    assign l_held         = r_left;
    assign cheat_activate = r_cheat;

endmodule

// File: tb/tb_mouse_tracker.sv
// Directed bench for mouse_tracker: table of packets with hand-computed
// positions/blocks, plus sequences for restart, cheat timing and peer reset.
module tb_mouse_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       interboard_rst = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [8:0] pkt_dx = '0;
    logic [8:0] pkt_dy = '0;
    logic       pkt_x_ovf = 1'b0;
    logic       pkt_y_ovf = 1'b0;
    logic [2:0] pkt_btn = '0;
    logic [9:0] mouse_x;
    logic [8:0] mouse_y;
    logic       mouse_valid;
    logic [4:0] mouse_block_x;
    logic [2:0] mouse_block_y;
    logic       map_busy, l_click, r_click, l_held, cheat_activate;

    mouse_tracker #(.CHEAT_GAP(100)) dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
        .pkt_valid(pkt_valid), .pkt_dx(pkt_dx), .pkt_dy(pkt_dy),
        .pkt_x_ovf(pkt_x_ovf), .pkt_y_ovf(pkt_y_ovf), .pkt_btn(pkt_btn),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_valid(mouse_valid),
        .mouse_block_x(mouse_block_x), .mouse_block_y(mouse_block_y),
        .map_busy(map_busy), .l_click(l_click), .r_click(r_click),
        .l_held(l_held), .cheat_activate(cheat_activate)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_cheat = 0;
    int n_lclk = 0;
    int n_vrise = 0;
    logic prev_v = 1'b0;

    always @(negedge clk) begin
        if (cheat_activate === 1'b1) n_cheat++;
        if (l_click === 1'b1) n_lclk++;
        if (mouse_valid === 1'b1 && prev_v !== 1'b1) n_vrise++;
        prev_v = mouse_valid;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    typedef struct {
        logic [8:0] dx;
        logic [8:0] dy;
        logic       xo;
        logic       yo;
        logic [2:0] btn;
        int ex, ey, el, er, eh, ev, ebx, eby;
    } vec_t;

    vec_t vecs[18];

    logic cap_l, cap_r, cap_h, cap_cheat, cap_v;
    logic pr_r, pr_cheat;

    function automatic vec_t mk(input logic [8:0] dx, input logic [8:0] dy,
                                input logic xo, input logic yo, input logic [2:0] btn,
                                input int ex, input int ey, input int el, input int er,
                                input int eh, input int ev, input int ebx, input int eby);
        vec_t v;
        v.dx = dx; v.dy = dy; v.xo = xo; v.yo = yo; v.btn = btn;
        v.ex = ex; v.ey = ey; v.el = el; v.er = er; v.eh = eh;
        v.ev = ev; v.ebx = ebx; v.eby = eby;
        return v;
    endfunction

    task automatic send_pkt(input logic [8:0] dx, input logic [8:0] dy,
                            input logic xo, input logic yo, input logic [2:0] btn);
        @(negedge clk);
        pkt_dx = dx; pkt_dy = dy; pkt_x_ovf = xo; pkt_y_ovf = yo; pkt_btn = btn;
        pkt_valid = 1'b1;
        @(negedge clk);
        pkt_valid = 1'b0;
        cap_l = l_click; cap_r = r_click; cap_h = l_held;
        cap_cheat = cheat_activate; cap_v = mouse_valid;
    endtask

    task automatic apply_vec(input int i);
        send_pkt(vecs[i].dx, vecs[i].dy, vecs[i].xo, vecs[i].yo, vecs[i].btn);
        chk($sformatf("v%0d x", i), int'(mouse_x), vecs[i].ex);
        chk($sformatf("v%0d y", i), int'(mouse_y), vecs[i].ey);
        chk($sformatf("v%0d l_click", i), int'(cap_l), vecs[i].el);
        chk($sformatf("v%0d r_click", i), int'(cap_r), vecs[i].er);
        chk($sformatf("v%0d l_held", i), int'(cap_h), vecs[i].eh);
        if (i == 0) begin
            chk("v0 valid_drop", int'(cap_v), 0);
            @(negedge clk);
            chk("v0 busy", int'(map_busy), 1);
        end
        repeat (25) @(negedge clk);
        chk($sformatf("v%0d busy_end", i), int'(map_busy), 0);
        chk($sformatf("v%0d valid", i), int'(mouse_valid), vecs[i].ev);
        if (vecs[i].ev != 0) begin
            chk($sformatf("v%0d block_x", i), int'(mouse_block_x), vecs[i].ebx);
            chk($sformatf("v%0d block_y", i), int'(mouse_block_y), vecs[i].eby);
        end
    endtask

    task automatic r_pair(input int gap);
        send_pkt(9'd0, 9'd0, 1'b0, 1'b0, 3'b010);
        pr_r = cap_r; pr_cheat = cap_cheat;
        send_pkt(9'd0, 9'd0, 1'b0, 1'b0, 3'b000);
        repeat (gap - 4) @(negedge clk);
    endtask

    int c0, l0, v0;

    initial begin
        vecs[0]  = mk(9'd100, 9'd50,  0, 0, 3'b000, 420, 190, 0, 0, 0, 1, 12, 2);
        vecs[1]  = mk(9'h101, 9'd0,   0, 0, 3'b000, 165, 190, 0, 0, 0, 1, 4, 2);
        vecs[2]  = mk(9'h101, 9'd0,   0, 0, 3'b000, 0,   190, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(9'h101, 9'd0,   0, 0, 3'b000, 0,   190, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(9'd40,  9'h1F6, 1, 0, 3'b000, 0,   200, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(9'd0,   9'd0,   0, 0, 3'b001, 355, 200, 1, 0, 1, 1, 10, 2);
        vecs[6]  = mk(9'd0,   9'd0,   0, 0, 3'b001, 355, 200, 0, 0, 1, 1, 10, 2);
        vecs[7]  = mk(9'd0,   9'd0,   0, 0, 3'b000, 355, 200, 0, 0, 0, 1, 10, 2);
        vecs[8]  = mk(9'd0,   9'd0,   0, 0, 3'b010, 355, 200, 0, 1, 0, 1, 10, 2);
        vecs[9]  = mk(9'd0,   9'd0,   0, 0, 3'b000, 355, 200, 0, 0, 0, 1, 10, 2);
        vecs[10] = mk(9'd0,   9'd255, 0, 0, 3'b000, 355, 0,   0, 0, 0, 0, 0, 0);
        vecs[11] = mk(9'd0,   9'h101, 0, 0, 3'b000, 355, 255, 0, 0, 0, 1, 10, 3);
        vecs[12] = mk(9'd0,   9'h101, 0, 0, 3'b000, 355, 479, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(9'd255, 9'd0,   0, 0, 3'b000, 610, 479, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(9'd255, 9'd0,   0, 0, 3'b000, 639, 479, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(9'h1E0, 9'd255, 0, 0, 3'b000, 607, 224, 0, 0, 0, 1, 17, 3);
        vecs[16] = mk(9'd0,   9'h111, 0, 0, 3'b000, 607, 463, 0, 0, 0, 1, 17, 7);
        vecs[17] = mk(9'd1,   9'd0,   0, 0, 3'b000, 608, 463, 0, 0, 0, 0, 0, 0);

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("rst x", int'(mouse_x), 320);
        chk("rst y", int'(mouse_y), 240);
        chk("rst valid", int'(mouse_valid), 0);
        chk("rst block_x", int'(mouse_block_x), 0);
        chk("rst block_y", int'(mouse_block_y), 0);
        chk("rst busy", int'(map_busy), 0);
        chk("rst pulses", int'({l_click, r_click, cheat_activate, l_held}), 0);
        repeat (25) @(negedge clk);
        chk("init valid", int'(mouse_valid), 1);
        chk("init block_x", int'(mouse_block_x), 9);
        chk("init block_y", int'(mouse_block_y), 3);

        for (int i = 0; i < 5; i++) apply_vec(i);

        // Second packet lands while the first is still being mapped.
        @(negedge clk); #1;
        v0 = n_vrise;
        @(negedge clk);
        pkt_dx = 9'd100; pkt_dy = 9'd0; pkt_x_ovf = 0; pkt_y_ovf = 0; pkt_btn = 3'b000;
        pkt_valid = 1'b1;
        @(negedge clk);
        pkt_valid = 1'b0;
        @(negedge clk);
        pkt_dx = 9'd255; pkt_valid = 1'b1;
        @(negedge clk);
        pkt_valid = 1'b0;
        chk("restart x", int'(mouse_x), 355);
        for (int k = 0; k < 40 && mouse_valid !== 1'b1; k++) @(negedge clk);
        chk("restart valid", int'(mouse_valid), 1);
        chk("restart block_x", int'(mouse_block_x), 10);
        chk("restart block_y", int'(mouse_block_y), 2);
        @(negedge clk); #1;
        chk("restart single publish", n_vrise - v0, 1);

        l0 = n_lclk;
        for (int i = 5; i < 18; i++) apply_vec(i);
        @(negedge clk); #1;
        chk("l_click count", n_lclk - l0, 1);

        // Five right clicks inside the gap fire once, aligned with the fifth.
        repeat (120) @(negedge clk);
        #1 c0 = n_cheat;
        for (int p = 0; p < 5; p++) r_pair(40);
        chk("cheat r_click5", int'(pr_r), 1);
        chk("cheat aligned", int'(pr_cheat), 1);
        @(negedge clk); #1;
        chk("cheat count", n_cheat - c0, 1);

        repeat (120) @(negedge clk);
        #1 c0 = n_cheat;
        for (int p = 0; p < 3; p++) r_pair(40);
        r_pair(150);
        r_pair(40);
        chk("gap r_click5", int'(pr_r), 1);
        @(negedge clk); #1;
        chk("gap no cheat", n_cheat - c0, 0);

        repeat (120) @(negedge clk);
        #1 c0 = n_cheat;
        r_pair(40);
        r_pair(40);
        send_pkt(9'd0, 9'd0, 1'b0, 1'b0, 3'b001);
        chk("lclr l_click", int'(cap_l), 1);
        send_pkt(9'd0, 9'd0, 1'b0, 1'b0, 3'b000);
        repeat (36) @(negedge clk);
        for (int p = 0; p < 3; p++) r_pair(40);
        @(negedge clk); #1;
        chk("lclr no cheat", n_cheat - c0, 0);

        // Peer reset mid-sequence, coinciding with a packet it must override.
        repeat (120) @(negedge clk);
        #1 c0 = n_cheat;
        for (int p = 0; p < 3; p++) r_pair(40);
        @(negedge clk);
        interboard_rst = 1'b1;
        pkt_dx = 9'd50; pkt_dy = 9'd0; pkt_btn = 3'b011; pkt_valid = 1'b1;
        @(negedge clk);
        interboard_rst = 1'b0;
        pkt_valid = 1'b0; pkt_btn = 3'b000;
        chk("ib x", int'(mouse_x), 320);
        chk("ib y", int'(mouse_y), 240);
        chk("ib valid", int'(mouse_valid), 0);
        chk("ib block_x", int'(mouse_block_x), 0);
        chk("ib block_y", int'(mouse_block_y), 0);
        chk("ib busy", int'(map_busy), 0);
        chk("ib pulses", int'({l_click, r_click, cheat_activate, l_held}), 0);
        repeat (38) @(negedge clk);
        r_pair(40);
        r_pair(40);
        @(negedge clk); #1;
        chk("ib no cheat", n_cheat - c0, 0);
        chk("ib remap valid", int'(mouse_valid), 1);
        chk("ib remap block_x", int'(mouse_block_x), 9);
        chk("ib remap block_y", int'(mouse_block_y), 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mouse_tracker.md
Name: mouse_tracker

Overview:
- Parametrised cursor engine between the PS/2 packet decoder and the game/display logic.
- Accumulates signed mouse deltas into a clamped screen position with programmable sensitivity.
- Maps the position onto a configurable block grid using a multi-cycle iterative divider.
- Produces edge-detected left/right click pulses and a timed right-click cheat-sequence detector.

Parameters:
- SCREEN_W, 640, horizontal pixels; x range 0..SCREEN_W-1
- SCREEN_H, 480, vertical pixels; y range 0..SCREEN_H-1
- GRID_X0, 32, left pixel of grid
- GRID_Y0, 80, top pixel of grid
- BLOCK_W, 32, block width in pixels
- BLOCK_H, 48, block height in pixels
- GRID_COLS, 18, number of block columns
- GRID_ROWS, 8, number of block rows
- SENS_SHIFT, 0, deltas arithmetic-right-shifted by this amount (0..3)
- CHEAT_CLICKS, 5, right clicks needed to fire cheat
- CHEAT_GAP, 25_000_000, max clk cycles allowed between consecutive right clicks

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- interboard_rst  input  1  synchronous clear from the peer board; same effect as rst
- pkt_valid  input  1  one-cycle strobe; packet fields are valid
- pkt_dx  input  9  signed 2's-complement X delta; positive = right
- pkt_dy  input  9  signed 2's-complement Y delta; positive = up
- pkt_x_ovf  input  1  X overflow flag
- pkt_y_ovf  input  1  Y overflow flag
- pkt_btn  input  3  {middle, right, left} button levels
- mouse_x  output  10  cursor x
- mouse_y  output  9  cursor y
- mouse_valid  output  1  cursor lies inside the grid and the block outputs are current
- mouse_block_x  output  5  column index
- mouse_block_y  output  3  row index
- map_busy  output  1  divider is running
- l_click  output  1  one-cycle pulse, left button press
- r_click  output  1  one-cycle pulse, right button press
- l_held  output  1  left button level
- cheat_activate  output  1  one-cycle pulse, cheat sequence complete

Behaviour:
- Reset state (rst=0 async, or interboard_rst=1 at a clk edge):
  - mouse_x=SCREEN_W/2, mouse_y=SCREEN_H/2.
  - Button registers cleared; cheat counter and gap timer cleared.
  - Divider forced to IDLE.
  - mouse_valid=0, mouse_block_x=0, mouse_block_y=0, map_busy=0.
  - All pulses 0.
- interboard_rst has priority over pkt_valid in the same cycle.
- Position update, on the cycle after pkt_valid:
  - sx = pkt_dx >>> SENS_SHIFT, sy = pkt_dy >>> SENS_SHIFT.
  - x' = clamp(x + sx, 0, SCREEN_W-1); y' = clamp(y - sy, 0, SCREEN_H-1). Y is inverted.
  - Sums computed at 12-bit signed width; no wrap-around is permitted.
  - If an axis's overflow flag is set, that axis is left unchanged; the other axis still updates.
- Buttons, updated only on pkt_valid:
  - l_click = new left & ~previous left; r_click likewise for the right button.
  - Pulses assert for exactly 1 cycle, one cycle after pkt_valid.
  - l_held follows the latched left level.
- Mapping FSM:
  - States IDLE -> LOAD -> DIV -> DONE -> IDLE.
  - LOAD is entered on the cycle after any position update. It captures rx=x-GRID_X0, ry=y-GRID_Y0 and out-of-range flags.
  - A position is out of range if x<GRID_X0, y<GRID_Y0, x>=GRID_X0+GRID_COLS*BLOCK_W, or y>=GRID_Y0+GRID_ROWS*BLOCK_H. Out of range goes straight to DONE with mouse_valid=0.
  - DIV: each cycle, rx-=BLOCK_W and column++ while rx>=BLOCK_W; rows handled the same way in parallel. Leave DIV when both axes are finished.
  - DONE: register mouse_block_x/y and set mouse_valid=1 for an in-range position.
  - map_busy=1 in LOAD and DIV. mouse_valid=0 while map_busy. Block outputs hold their old values until DONE.
  - Worst case from pkt_valid to DONE is max(GRID_COLS, GRID_ROWS)+3 cycles.
  - A new position update during LOAD or DIV restarts the FSM at LOAD with the newest position. The stale result is never published.
- Cheat detector:
  - Each r_click increments cnt and reloads the gap timer to CHEAT_GAP.
  - The timer decrements every cycle; when it reaches 0, cnt is cleared.
  - An l_click clears cnt.
  - When cnt reaches CHEAT_CLICKS, cheat_activate pulses 1 cycle, aligned with the final r_click, and cnt is cleared.
  - A timeout and an r_click in the same cycle: the r_click wins, cnt=1.

Test Plan:
1. Release rst, no packets -> mouse_x=320, mouse_y=240; mapping completes with mouse_valid=1, block_x=(320-32)/32=9, block_y=(240-80)/48=3.
2. pkt_dx=+100, pkt_dy=+50 at reset position -> mouse_x=420, mouse_y=190 one cycle later; mouse_valid returns to 1 with block_x=12, block_y=2.
3. Clamp and overflow: pkt_dx=-255 repeated 3 times -> mouse_x=0, mouse_valid=0. Then pkt_dx=+40, pkt_x_ovf=1, pkt_dy=-10 -> x stays 0, y increases by 10.
4. Packet issued while map_busy=1 (second packet two cycles after the first) -> only the second position's block is published; mouse_valid never pulses for the first.
5. pkt_btn left 0->1->1->0 on successive packets -> exactly one l_click pulse; l_held high for the two middle packets.
6. With CHEAT_GAP set to 100 in sim:
   - 5 right press/release pairs 40 cycles apart -> cheat_activate pulses once.
   - Repeat with a 150-cycle gap before the 5th press -> no pulse.
   - Repeat with an l_click inserted -> no pulse.
   - Assert interboard_rst mid-sequence -> state returns to reset values.
